// File: rtl/button_event_queue.sv
// Button event queue: synchronizes, debounces and edge-detects four buttons,
// queueing each press as a colour code that the processor pops by polling.
//
// Ports:
//   clock, reset        - system clock, synchronous active-high reset
//   red/blue/green/yellow_button - raw active-high pins (asynchronous)
//   poll                - high while the processor addresses the poll word
//   rd_data             - head event (0 empty, 1 red, 2 blue, 3 green, 4 yellow)
//   count               - number of queued events
//   overflow            - sticky flag: an event was dropped on a full queue
module button_event_queue #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int DEPTH           = 8
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    red_button,
    input  logic                    blue_button,
    input  logic                    green_button,
    input  logic                    yellow_button,
    input  logic                    poll,
    output logic [31:0]             rd_data,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST   = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [AW:0]   FULL_COUNT = (AW + 1)'(DEPTH);

    // Bit 0 is red (highest priority) through bit 3 yellow.
    logic [3:0]    raw;
    logic [3:0]    sync_a;
    logic [3:0]    sync_b;
    logic [3:0]    stable;
    logic [CW-1:0] db_cnt [4];
    logic [3:0]    rise;
    logic [3:0]    pending;
    logic [3:0]    pending_next;
    logic [3:0]    grant;
    logic [2:0]    grant_code;
    logic          push;

    logic          poll_d;
    logic          pop_req;
    logic          empty;
    logic          full;
    logic          pop;
    logic          wr_en;
    logic          drop;

    logic [2:0]    mem [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;

    assign raw = {yellow_button, green_button, blue_button, red_button};

    // Two-flop synchronizer; only sync_b is seen downstream.
    always_ff @(posedge clock) begin
        if (reset) begin
            sync_a <= '0;
            sync_b <= '0;
        end else begin
            sync_a <= raw;
            sync_b <= sync_a;
        end
    end

    // Debounce: a new level must persist DEBOUNCE_CYCLES samples in a row.
    always_ff @(posedge clock) begin
        if (reset) begin
            stable <= '0;
            for (int i = 0; i < 4; i++) begin
                db_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (sync_b[i] == stable[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == CNT_LAST) begin
                    stable[i] <= sync_b[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + CW'(1);
                end
            end
        end
    end

    // A press is the debounced level about to flip from 0 to 1.
    always_comb begin
        rise = '0;
        for (int i = 0; i < 4; i++) begin
            rise[i] = ~stable[i] & sync_b[i] & (db_cnt[i] == CNT_LAST);
        end
    end

    // Fixed-priority pick of one pending press per cycle.
    always_comb begin
        grant      = '0;
        grant_code = '0;
        priority case (1'b1)
            pending[0]: begin
                grant      = 4'b0001;
                grant_code = 3'd1;
            end
            pending[1]: begin
                grant      = 4'b0010;
                grant_code = 3'd2;
            end
            pending[2]: begin
                grant      = 4'b0100;
                grant_code = 3'd3;
            end
            pending[3]: begin
                grant      = 4'b1000;
                grant_code = 3'd4;
            end
            default: begin
                grant      = '0;
                grant_code = '0;
            end
        endcase
    end

    assign push = |pending;

    // A fresh press on the granted button re-arms it rather than being lost.
    assign pending_next = (pending & ~grant) | rise;

    always_ff @(posedge clock) begin
        if (reset) begin
            pending <= '0;
        end else begin
            pending <= pending_next;
        end
    end

    // Pop only on the rising edge of poll so a stalled load pops once.
    assign pop_req = poll & ~poll_d;
    assign empty   = (count == '0);
    assign full    = (count == FULL_COUNT);
    assign pop     = pop_req & ~empty;
    assign wr_en   = push & (~full | pop);
    assign drop    = push & full & ~pop;

    always_ff @(posedge clock) begin
        if (reset) begin
            poll_d <= 1'b0;
        end else begin
            poll_d <= poll;
        end
    end

    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem[wptr] <= grant_code;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clock) begin
        if (reset) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (wr_en) begin
                wptr <= wptr + AW'(1);
            end
            if (pop) begin
                rptr <= rptr + AW'(1);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            count <= '0;
        end else begin
            unique case ({wr_en, pop})
                2'b10:   count <= count + (AW + 1)'(1);
                2'b01:   count <= count - (AW + 1)'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            overflow <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
        end
    end

    // Show-ahead head: valid in the same cycle poll rises.
    always_comb begin
        rd_data = '0;
        if (!empty) begin
            rd_data = {29'd0, mem[rptr]};
        end
    end

endmodule

// File: tb/tb_button_event_queue.sv
// Testbench for button_event_queue: directed scenarios plus random button
// and poll activity, checked every cycle against a queue-based model.
module tb_button_event_queue;

    localparam int DEB   = 4;
    localparam int DEPTH = 4;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        poll  = 1'b0;
    logic [3:0]  btn   = 4'b0;
    logic [31:0] rd_data;
    logic [2:0]  count;
    logic        overflow;

    int checks = 0;
    int errors = 0;

    // Reference model state
    bit [3:0] raw_log[$];
    bit [3:0] seen_log[$];
    bit [3:0] stab_m;
    bit [3:0] pend_m;
    bit       ovf_m;
    bit       poll_prev;
    int       q[$];

    always #5 clock = ~clock;

    button_event_queue #(
        .DEBOUNCE_CYCLES(DEB),
        .DEPTH(DEPTH)
    ) dut (
        .clock(clock),
        .reset(reset),
        .red_button(btn[0]),
        .blue_button(btn[1]),
        .green_button(btn[2]),
        .yellow_button(btn[3]),
        .poll(poll),
        .rd_data(rd_data),
        .count(count),
        .overflow(overflow)
    );

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance the model by one clock edge using the inputs the DUT samples.
    task automatic model_edge();
        bit [3:0] seen;
        bit [3:0] rise_m;
        bit       all_diff;
        int       code;
        rise_m = '0;
        code   = 0;
        if (reset) begin
            raw_log.delete();
            seen_log.delete();
            stab_m    = '0;
            pend_m    = '0;
            ovf_m     = 1'b0;
            poll_prev = 1'b0;
            q.delete();
            return;
        end
        // The debouncer sees the pin as it was two edges ago.
        seen = (raw_log.size() >= 2) ? raw_log[raw_log.size() - 2] : 4'b0;
        raw_log.push_back(btn);
        if (raw_log.size() > 2) void'(raw_log.pop_front());
        seen_log.push_back(seen);
        if (seen_log.size() > DEB) void'(seen_log.pop_front());
        // Level flips once DEB consecutive samples disagree with it.
        for (int b = 0; b < 4; b++) begin
            if (seen_log.size() == DEB) begin
                all_diff = 1'b1;
                foreach (seen_log[e]) begin
                    if (seen_log[e][b] == stab_m[b]) all_diff = 1'b0;
                end
                if (all_diff) begin
                    stab_m[b] = ~stab_m[b];
                    if (stab_m[b]) rise_m[b] = 1'b1;
                end
            end
        end
        for (int b = 0; b < 4; b++) begin
            if (pend_m[b]) begin
                code      = b + 1;
                pend_m[b] = 1'b0;
                break;
            end
        end
        if (poll && !poll_prev && q.size() > 0) void'(q.pop_front());
        if (code != 0) begin
            if (q.size() < DEPTH) q.push_back(code);
            else ovf_m = 1'b1;
        end
        pend_m    = pend_m | rise_m;
        poll_prev = poll;
    endtask

    task automatic tick();
        model_edge();
        @(posedge clock);
        #1;
        check("count", 32'(count), 32'(q.size()));
        check("rd_data", rd_data, (q.size() > 0) ? 32'(q[0]) : 32'd0);
        check("overflow", 32'(overflow), 32'(ovf_m));
    endtask

    task automatic ticks(int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic press(int b);
        btn[b] = 1'b1;
        ticks(8);
        btn[b] = 1'b0;
        ticks(8);
    endtask

    task automatic pop_once();
        poll = 1'b1;
        tick();
        poll = 1'b0;
        tick();
    endtask

    initial begin
        reset = 1'b1;
        ticks(2);
        reset = 1'b0;
        check("reset_count", 32'(count), 32'd0);
        check("reset_rd", rd_data, 32'd0);
        check("reset_ovf", 32'(overflow), 32'd0);
        ticks(20);
        check("idle_count", 32'(count), 32'd0);
        check("idle_rd", rd_data, 32'd0);

        // Short glitch must never register.
        btn[1] = 1'b1;
        ticks(3);
        btn[1] = 1'b0;
        ticks(10);
        check("glitch_count", 32'(count), 32'd0);

        // Long hold yields one event; a held poll pops once.
        btn[0] = 1'b1;
        ticks(20);
        btn[0] = 1'b0;
        ticks(10);
        check("red_count", 32'(count), 32'd1);
        check("red_rd", rd_data, 32'd1);
        poll = 1'b1;
        ticks(3);
        poll = 1'b0;
        tick();
        check("red_pop_count", 32'(count), 32'd0);
        check("red_pop_rd", rd_data, 32'd0);

        // Simultaneous presses queue in priority order.
        btn = 4'b1100;
        ticks(10);
        btn = 4'b0000;
        ticks(10);
        check("gy_count", 32'(count), 32'd2);
        check("gy_head", rd_data, 32'd3);
        pop_once();
        check("gy_second", rd_data, 32'd4);
        pop_once();
        check("gy_empty", rd_data, 32'd0);

        // Five presses into a four-deep queue.
        press(0);
        press(1);
        press(2);
        press(3);
        press(0);
        check("full_count", 32'(count), 32'd4);
        check("full_ovf", 32'(overflow), 32'd1);
        for (int i = 0; i < 4; i++) begin
            check("full_order", rd_data, 32'(i + 1));
            pop_once();
        end
        check("drained_rd", rd_data, 32'd0);
        check("ovf_sticky", 32'(overflow), 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        check("ovf_cleared", 32'(overflow), 32'd0);

        // Poll edge lands on the cycle a new event is pushed.
        press(0);
        press(1);
        check("pp_pre_count", 32'(count), 32'd2);
        btn[2] = 1'b1;
        ticks(6);
        poll = 1'b1;
        tick();
        check("pp_count", 32'(count), 32'd2);
        poll = 1'b0;
        tick();
        check("pp_head", rd_data, 32'd2);
        btn[2] = 1'b0;
        ticks(10);
        pop_once();
        check("pp_tail", rd_data, 32'd3);
        pop_once();
        check("pp_empty", 32'(count), 32'd0);

        // Several fill/drain rounds exercise pointer wrap.
        for (int r = 0; r < 3; r++) begin
            for (int b = 0; b < 4; b++) press(b);
            check("wrap_full", 32'(count), 32'd4);
            for (int i = 0; i < 4; i++) begin
                check("wrap_order", rd_data, 32'(i + 1));
                pop_once();
            end
            check("wrap_empty", 32'(count), 32'd0);
        end

        // Random pins, polls and occasional resets against the model.
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 5) == 0) begin
                btn[$urandom_range(0, 3)] ^= 1'b1;
            end
            poll  = ($urandom_range(0, 2) == 0);
            reset = ($urandom_range(0, 499) == 0);
            tick();
        end
        reset = 1'b0;
        poll  = 1'b0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
